// File: rtl/multdiv_pkg.sv
// Shared types and latency helpers for the iterative multiply/divide unit.
// The RTL and its bench both use these so the two agree on timing.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DIV
  } state_t;

  typedef enum logic [2:0] {
    BOOTH_ZERO,
    BOOTH_POS1,
    BOOTH_POS2,
    BOOTH_NEG1,
    BOOTH_NEG2
  } booth_t;

  // Edges from the start edge to the data_resultRDY edge.
  function automatic int mult_latency(input int width, input int bits_per_cycle);
    return width / bits_per_cycle + 1;
  endfunction

  function automatic int div_latency(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/multdiv_if.sv
// Operand/control/result bundle between a requester and multdiv_unit.
interface multdiv_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_booth_step.sv
// Booth digit select: maps a 3-bit multiplier window to a digit and the
// unsigned-direction addend (0, M or 2M); the caller subtracts for negative digits.
module multdiv_booth_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        [2:0]       window,
  input  logic signed [WIDTH-1:0] mcand,
  output booth_t                  digit,
  output logic signed [WIDTH+1:0] addend
);

  logic signed [WIDTH+1:0] mcand_x;

  assign mcand_x = {{2{mcand[WIDTH-1]}}, mcand};

  always_comb begin
    digit = BOOTH_ZERO;
    case (window)
      3'b001, 3'b010: digit = BOOTH_POS1;
      3'b011:         digit = BOOTH_POS2;
      3'b100:         digit = BOOTH_NEG2;
      3'b101, 3'b110: digit = BOOTH_NEG1;
      default:        digit = BOOTH_ZERO;
    endcase
  end

  always_comb begin
    addend = '0;
    case (digit)
      BOOTH_POS1, BOOTH_NEG1: addend = mcand_x;
      BOOTH_POS2, BOOTH_NEG2: addend = mcand_x <<< 1;
      default:                addend = '0;
    endcase
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiplier (radix-2/4 Booth) and restoring divider sharing
// one WIDTH+2-bit adder/subtractor; fixed latency, one-cycle completion strobe.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH               = 32,
  parameter int MULT_BITS_PER_CYCLE = 2
) (
  input logic      clock,
  input logic      reset,
  multdiv_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int SHIFT = MULT_BITS_PER_CYCLE;
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(mult_latency(WIDTH, MULT_BITS_PER_CYCLE) - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(div_latency(WIDTH) - 1);
  localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t                  state, state_nxt;
  logic        [CNT_W-1:0] cnt;
  logic                    start_mult, start_div, last_iter;

  logic signed [WIDTH+1:0] acc;
  logic        [WIDTH-1:0] mq;
  logic signed [WIDTH-1:0] opnd;
  logic                    prev, neg_res, div_zero, div_ovf;

  logic        [WIDTH-1:0] result_q;
  logic                    exc_q, rdy_q;

  logic        [2:0]       window;
  booth_t                  digit;
  logic signed [WIDTH+1:0] booth_addend;

  logic signed [WIDTH+1:0] add_a, add_b, add_sum;
  logic                    add_sub, trial_ok, mult_ovf;

  assign start_mult = bus.ctrl_MULT;
  assign start_div  = bus.ctrl_DIV & ~bus.ctrl_MULT;
  assign last_iter  = (state == MULT) ? (cnt == MULT_LAST) : (cnt == DIV_LAST);

  // Radix-2 reuses the radix-4 table with the current bit duplicated.
  assign window = (SHIFT == 2) ? {mq[1:0], prev} : {mq[0], mq[0], prev};

  multdiv_booth_step #(.WIDTH(WIDTH)) u_booth (
    .window (window),
    .mcand  (opnd),
    .digit  (digit),
    .addend (booth_addend)
  );

  // Shared adder: |A| in IDLE, partial products in MULT, trial subtract and
  // final sign fix-up in DIV. A negative divisor is added instead of subtracted.
  always_comb begin
    add_a   = '0;
    add_b   = {{2{bus.data_operandA[WIDTH-1]}}, bus.data_operandA};
    add_sub = bus.data_operandA[WIDTH-1];
    case (state)
      MULT: begin
        add_a   = acc;
        add_b   = booth_addend;
        add_sub = (digit == BOOTH_NEG1) || (digit == BOOTH_NEG2);
      end
      DIV: begin
        if (last_iter) begin
          add_a   = '0;
          add_b   = {2'b00, mq};
          add_sub = neg_res;
        end else begin
          add_a   = {acc[WIDTH:0], mq[WIDTH-1]};
          add_b   = {{2{opnd[WIDTH-1]}}, opnd};
          add_sub = ~opnd[WIDTH-1];
        end
      end
      default: ;
    endcase
  end

  assign add_sum  = add_a + (add_sub ? ~add_b : add_b) + (WIDTH+2)'(add_sub);
  assign trial_ok = ~add_sum[WIDTH+1];
  assign mult_ovf = (acc != {(WIDTH+2){mq[WIDTH-1]}});

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_mult)     state_nxt = MULT;
        else if (start_div) state_nxt = DIV;
      end
      MULT, DIV: if (last_iter) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (state == IDLE)  cnt <= '0;
      else if (!last_iter) cnt <= cnt + CNT_W'(1);
      if (state != IDLE && last_iter) begin
        rdy_q <= 1'b1;
        if (state == MULT) begin
          result_q <= mq;
          exc_q    <= mult_ovf;
        end else begin
          result_q <= div_zero ? '0 : add_sum[WIDTH-1:0];
          exc_q    <= div_zero | div_ovf;
        end
      end
    end
  end

  // Datapath registers carry no reset; they are loaded on every accepted start.
  always_ff @(posedge clock) begin
    case (state)
      IDLE: begin
        if (start_mult) begin
          acc  <= '0;
          mq   <= bus.data_operandB;
          prev <= 1'b0;
          opnd <= bus.data_operandA;
        end else if (start_div) begin
          acc      <= '0;
          mq       <= add_sum[WIDTH-1:0];
          opnd     <= bus.data_operandB;
          neg_res  <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
          div_zero <= (bus.data_operandB == '0);
          div_ovf  <= (bus.data_operandA == MOST_NEG) && (bus.data_operandB == '1);
        end
      end
      MULT: begin
        if (!last_iter) begin
          acc  <= add_sum >>> SHIFT;
          mq   <= {add_sum[SHIFT-1:0], mq[WIDTH-1:SHIFT]};
          prev <= mq[SHIFT-1];
        end
      end
      DIV: begin
        if (!last_iter) begin
          acc <= trial_ok ? add_sum : add_a;
          mq  <= {mq[WIDTH-2:0], trial_ok};
        end
      end
      default: ;
    endcase
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = (state != IDLE);

endmodule
